// File: rtl/sum_acc_pkg.sv
// -----------------------------------------------------------------------------
// sum_acc_pkg
// Shared definitions for the sum_accumulator block.
//   state_t : frame FSM states (ACC = collecting samples, HOLD = result held)
//   OPND_W  : width of one adder result {carry, sum}
//   CNT_W   : width of the per-frame sample counter
// Optional build macro used by this block: SUM_ACC_SATURATE_EN
// -----------------------------------------------------------------------------
package sum_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int OPND_W = 4;
    localparam int CNT_W  = 8;

endpackage : sum_acc_pkg

// File: rtl/sum_acc_datapath.sv
// -----------------------------------------------------------------------------
// sum_acc_datapath
// Combinational accumulate step: next_acc = acc + operand, with carry out.
// Build option SUM_ACC_SATURATE_EN: when defined, a carry clamps the result to
// all-ones; otherwise the result wraps modulo 2^ACC_W.
// Ports:
//   i_acc      [ACC_W-1:0]  current accumulator value
//   i_opnd     [OPND_W-1:0] operand {carry, sum} from the adder stage
//   i_clear                 force next accumulator to zero
//   o_acc_next [ACC_W-1:0]  next accumulator value
//   o_carry                 addition overflowed ACC_W bits
// -----------------------------------------------------------------------------
module sum_acc_datapath
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [OPND_W-1:0] i_opnd,
    input  logic              i_clear,
    output logic [ACC_W-1:0]  o_acc_next,
    output logic              o_carry
);

    // One extra bit holds the carry out of the ACC_W-bit sum.
    logic [ACC_W:0] w_sum;

    assign w_sum   = {1'b0, i_acc} + {{(ACC_W + 1 - OPND_W){1'b0}}, i_opnd};
    assign o_carry = w_sum[ACC_W] & ~i_clear;

    always_comb begin
        if (i_clear) begin
            o_acc_next = '0;
        end
`ifdef SUM_ACC_SATURATE_EN
        // Operands are non-negative, so once clamped any further addition
        // either adds zero or carries again: the value stays at all-ones.
        else if (w_sum[ACC_W]) begin
            o_acc_next = '1;
        end
`endif
        else begin
            o_acc_next = w_sum[ACC_W-1:0];
        end
    end

endmodule : sum_acc_datapath

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
// Accumulates adder results ({in_cy, in_sum}) over frames of FRAME_LEN samples
// and holds the frame total, sample count and overflow flag until accepted.
// Build option SUM_ACC_SATURATE_EN: saturate instead of wrap on overflow.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     input handshake (in_ready registered)
//   in_sum[2:0], in_cy      operand = {in_cy, in_sum}
//   flush                   close the current frame early if it holds data
//   out_valid / out_ready   output handshake (out_valid registered)
//   out_acc[ACC_W-1:0]      frame total
//   out_count[7:0]          samples in the frame
//   out_ovf                 total exceeded 2^ACC_W-1 during the frame
// -----------------------------------------------------------------------------
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sum,
    input  logic              in_cy,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [OPND_W-1:0]   w_opnd;
    logic                w_take;
    logic [CNT_W-1:0]    w_cnt_upd;
    logic                w_frame_done;
    logic                w_clear;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_carry;

    assign w_opnd    = {in_cy, in_sum};
    assign w_take    = in_valid && (r_state == ACC);
    assign w_cnt_upd = r_count + CNT_W'(w_take);

    // A sample accepted together with flush belongs to the frame being closed,
    // so both conditions look at the updated count.
    assign w_frame_done = (w_cnt_upd == CNT_W'(FRAME_LEN)) ||
                          (flush && (w_cnt_upd != '0));

    // In HOLD the datapath only ever supplies the cleared value for the
    // accumulator reload on result acceptance.
    assign w_clear = (r_state == HOLD);

    sum_acc_datapath #(
        .ACC_W (ACC_W)
    ) u_datapath (
        .i_acc      (r_acc),
        .i_opnd     (w_opnd),
        .i_clear    (w_clear),
        .o_acc_next (w_acc_next),
        .o_carry    (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_take) begin
                        r_acc   <= w_acc_next;
                        r_count <= w_cnt_upd;
                        r_ovf   <= r_ovf | w_carry;
                    end
                    if (w_frame_done) begin
                        r_state     <= HOLD;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // flush and in_valid are ignored while the result is held.
                    if (out_ready) begin
                        r_acc       <= w_acc_next;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= ACC;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ACC;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_acc   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule : sum_accumulator
